// File: rtl/hamming_decoder_pipe_pkg.sv
// hamming_decoder_pipe_pkg
// Shared constants and helpers for the 17-bit Hamming codeword decoder.
// Codeword bit positions run 1..17. Parity bits sit at the power-of-two
// positions and the 12 data bits fill the remaining positions in ascending
// order (data[0] at position 3 ... data[11] at position 17).
// Optional build macro used by the top: HAMMING_DEC_STATS_EN.
package hamming_decoder_pipe_pkg;

  localparam int CODE_W  = 17;
  localparam int DATA_W  = 12;
  localparam int SYN_W   = 5;
  localparam int NUM_PAR = 5;

  localparam int PARITY_POS [NUM_PAR] = '{1, 2, 4, 8, 16};

  // True when a codeword position holds a parity bit rather than data.
  function automatic logic isParityPos(input int pos);
    isParityPos = 1'b0;
    for (int k = 0; k < NUM_PAR; k++) begin
      if (PARITY_POS[k] == pos) isParityPos = 1'b1;
    end
  endfunction

  // Maps a data index (0..DATA_W-1) to its codeword position (1..CODE_W).
  // Walks the codeword skipping parity slots, so data[0] lands on 3.
  function automatic int dataPos(input int idx);
    int cnt;
    dataPos = 0;
    cnt     = 0;
    for (int p = 1; p <= CODE_W; p++) begin
      if (!isParityPos(p)) begin
        if (cnt == idx) dataPos = p;
        cnt++;
      end
    end
  endfunction

endpackage

// File: rtl/hamming_decoder_pipe_syndrome.sv
// hamming_syndrome
// Purely combinational syndrome generator for a 17-bit Hamming codeword.
// Syndrome bit k is the XOR of every codeword position whose index has
// bit k set, so the syndrome equals the XOR of the indices of all set bits.
// A zero syndrome means the word is consistent; otherwise it names the
// position of a single flipped bit (or something beyond the word).
// Ports:
//   i_code     [CODE_W:1]  codeword, bit p is position p
//   o_syndrome [SYN_W-1:0] computed syndrome
module hamming_syndrome
  import hamming_decoder_pipe_pkg::*;
(
  input  logic [CODE_W:1]  i_code,
  output logic [SYN_W-1:0] o_syndrome
);

  // Fold each set position index into the running XOR.
  always_comb begin
    o_syndrome = '0;
    for (int p = 1; p <= CODE_W; p++) begin
      if (i_code[p]) o_syndrome = o_syndrome ^ p[SYN_W-1:0];
    end
  end

endmodule

// File: rtl/hamming_decoder_pipe.sv
// hamming_decoder_pipe
// Two-stage valid/ready Hamming decoder for 17-bit codewords carrying 12
// data bits. Stage 1 registers the codeword with its syndrome; stage 2
// corrects a single-bit error, extracts the data and presents it with flags.
// Syndromes 18..31 cannot name a codeword bit and are reported as
// uncorrectable with the data extracted raw. Double errors that alias onto
// a valid position are miscorrected; that is the intended behaviour.
// Optional build macro: HAMMING_DEC_STATS_EN adds saturating counters of
// corrected and uncorrectable words delivered to the sink; without it the
// counter ports are tied to zero.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   upstream handshake, in_code [17:1] codeword
//   out_valid/out_ready downstream handshake
//   out_data            corrected 12-bit data
//   out_syndrome        raw 5-bit syndrome
//   out_corrected       single error corrected (syndrome 1..17)
//   out_uncorrectable   syndrome 18..31
//   corr_count          corrected words delivered (stats build)
//   uncorr_count        uncorrectable words delivered (stats build)
module hamming_decoder_pipe
  import hamming_decoder_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W:1]   in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SYN_W-1:0]  out_syndrome,
  output logic              out_corrected,
  output logic              out_uncorrectable,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count
);

  logic [SYN_W-1:0]  w_syndrome;
  logic              w_s2Advance;
  logic [CODE_W:1]   w_fixedCode;
  logic [DATA_W-1:0] w_data;
  logic              w_corr;
  logic              w_uncorr;

  logic              r_s1Valid;
  logic [CODE_W:1]   r_s1Code;
  logic [SYN_W-1:0]  r_s1Syndrome;

  logic              r_outValid;
  logic [DATA_W-1:0] r_outData;
  logic [SYN_W-1:0]  r_outSyndrome;
  logic              r_outCorrected;
  logic              r_outUncorrectable;

  hamming_syndrome u_syndrome (
    .i_code     (in_code),
    .o_syndrome (w_syndrome)
  );

  // Stage 2 can take a new word when it is empty or its word leaves now.
  // Stage 1 can accept when it is empty or it hands off to stage 2, which
  // gives a combinational out_ready -> in_ready path but none from in_valid.
  assign w_s2Advance = !r_outValid || out_ready;
  assign in_ready    = !r_s1Valid || w_s2Advance;

  // Stage 1: capture codeword and syndrome on every accepted word; when it
  // hands off without a new arrival it simply empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1Valid    <= 1'b0;
      r_s1Code     <= '0;
      r_s1Syndrome <= '0;
    end else if (in_ready) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Code     <= in_code;
        r_s1Syndrome <= w_syndrome;
      end
    end
  end

  // Correction: a syndrome inside the codeword names the bit to flip, even
  // when it is a parity position (data then comes out unchanged).
  always_comb begin
    w_corr      = (r_s1Syndrome != '0) && (r_s1Syndrome <= SYN_W'(CODE_W));
    w_uncorr    = r_s1Syndrome > SYN_W'(CODE_W);
    w_fixedCode = r_s1Code;
    for (int p = 1; p <= CODE_W; p++) begin
      if (w_corr && (r_s1Syndrome == p[SYN_W-1:0])) w_fixedCode[p] = ~r_s1Code[p];
    end
    w_data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_data[i] = w_fixedCode[dataPos(i)];
    end
  end

  // Stage 2: result registers only load on a real handoff, so payload and
  // flags hold while stalled and keep their last value after out_valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid         <= 1'b0;
      r_outData          <= '0;
      r_outSyndrome      <= '0;
      r_outCorrected     <= 1'b0;
      r_outUncorrectable <= 1'b0;
    end else if (w_s2Advance) begin
      r_outValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outData          <= w_data;
        r_outSyndrome      <= r_s1Syndrome;
        r_outCorrected     <= w_corr;
        r_outUncorrectable <= w_uncorr;
      end
    end
  end

  assign out_valid         = r_outValid;
  assign out_data          = r_outData;
  assign out_syndrome      = r_outSyndrome;
  assign out_corrected     = r_outCorrected;
  assign out_uncorrectable = r_outUncorrectable;

`ifdef HAMMING_DEC_STATS_EN
  logic [CNT_W-1:0] r_corrCount;
  logic [CNT_W-1:0] r_uncorrCount;

  // Count words as the sink takes them; each counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_corrCount   <= '0;
      r_uncorrCount <= '0;
    end else if (r_outValid && out_ready) begin
      if (r_outCorrected && (r_corrCount != '1))
        r_corrCount <= r_corrCount + CNT_W'(1);
      if (r_outUncorrectable && (r_uncorrCount != '1))
        r_uncorrCount <= r_uncorrCount + CNT_W'(1);
    end
  end

  assign corr_count   = r_corrCount;
  assign uncorr_count = r_uncorrCount;
`else
  assign corr_count   = '0;
  assign uncorr_count = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// tb_hamming_decoder_pipe
// Scoreboard bench for hamming_decoder_pipe. The driver pushes the expected
// result of every accepted codeword; an independent monitor pops and
// compares whenever the decoder hands a word to the sink.
module tb_hamming_decoder_pipe;

  localparam int CNT_W = 16;

  typedef struct {
    logic [11:0] data;
    logic [4:0]  syn;
    logic        corr;
    logic        uncorr;
    int          acceptCycle;
    bit          latChk;
  } expT;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [17:1]      in_code;
  logic             out_valid;
  logic             out_ready;
  logic [11:0]      out_data;
  logic [4:0]       out_syndrome;
  logic             out_corrected;
  logic             out_uncorrectable;
  logic [CNT_W-1:0] corr_count;
  logic [CNT_W-1:0] uncorr_count;

  expT  expQ[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;
  int   modelCorr = 0;
  int   modelUncorr = 0;
  logic prevValid = 1'b0;
  logic prevReady = 1'b0;
  logic [11:0] prevData = '0;

  hamming_decoder_pipe #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_code           (in_code),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_syndrome      (out_syndrome),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .corr_count        (corr_count),
    .uncorr_count      (uncorr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Syndrome as the XOR of indices of all set positions.
  function automatic logic [4:0] synOf(input logic [16:0] c);
    int s = 0;
    for (int p = 1; p <= 17; p++) if (c[p-1]) s = s ^ p;
    return s[4:0];
  endfunction

  function automatic bit isPow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Place data on non-power-of-two positions, then set parity bits so the
  // whole word has a zero syndrome.
  function automatic logic [16:0] encode(input logic [11:0] d);
    logic [16:0] c = '0;
    logic [4:0]  s;
    int j = 0;
    for (int p = 1; p <= 17; p++) begin
      if (!isPow2(p)) begin
        c[p-1] = d[j];
        j++;
      end
    end
    s = synOf(c);
    for (int k = 0; k < 5; k++) if (s[k]) c[(1 << k) - 1] = 1'b1;
    return c;
  endfunction

  function automatic expT model(input logic [16:0] code);
    expT e;
    logic [16:0] f = code;
    int s = int'(synOf(code));
    int j = 0;
    e.syn    = s[4:0];
    e.corr   = (s >= 1) && (s <= 17);
    e.uncorr = s > 17;
    if (e.corr) f[s-1] = ~f[s-1];
    e.data = '0;
    for (int p = 1; p <= 17; p++) begin
      if (!isPow2(p)) begin
        e.data[j] = f[p-1];
        j++;
      end
    end
    e.acceptCycle = 0;
    e.latChk = 1'b0;
    return e;
  endfunction

  function automatic logic [16:0] randCode();
    logic [16:0] c = encode(12'($urandom));
    int nErr = int'($urandom_range(0, 2));
    for (int i = 0; i < nErr; i++) begin
      int pos = int'($urandom_range(1, 31));
      if (pos <= 17) c[pos-1] = ~c[pos-1];
    end
    return c;
  endfunction

  // One cycle of stimulus; accepted words push their expected result.
  task automatic applyStimulus(input logic v, input logic [16:0] code, input logic rdy,
                               input bit latChk, input bit useDirect, input expT direct,
                               output bit acc);
    expT e;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_code   = code;
    out_ready = rdy;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) begin
      e = useDirect ? direct : model(code);
      e.acceptCycle = cycle;
      e.latChk = latChk;
      expQ.push_back(e);
    end
  endtask

  task automatic sendDirected(input logic [16:0] code, input logic [11:0] d, input logic [4:0] s,
                              input logic c, input logic u);
    expT e;
    bit acc;
    e.data = d; e.syn = s; e.corr = c; e.uncorr = u;
    e.acceptCycle = 0; e.latChk = 1'b0;
    applyStimulus(1'b1, code, 1'b1, 1'b1, 1'b1, e, acc);
    checkOutput("directedAccept", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n, input logic rdy);
    expT e;
    bit acc;
    e = model(17'h0);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 17'h0, rdy, 1'b0, 1'b0, e, acc);
  endtask

  // Monitor: compares every handshake against the scoreboard and checks
  // that a stalled word stays put.
  always @(negedge clk) begin
    expT e;
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (prevValid && !prevReady) begin
        checkOutput("holdValid", 32'(out_valid), 32'd1);
        checkOutput("holdData", 32'(out_data), 32'(prevData));
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedOutput: got data %0h want nothing (cycle %0d)", out_data, cycle);
        end else begin
          e = expQ.pop_front();
          checkOutput("data", 32'(out_data), 32'(e.data));
          checkOutput("syndrome", 32'(out_syndrome), 32'(e.syn));
          checkOutput("corrected", 32'(out_corrected), 32'(e.corr));
          checkOutput("uncorrectable", 32'(out_uncorrectable), 32'(e.uncorr));
          if (e.latChk) checkOutput("latency", 32'(cycle - e.acceptCycle), 32'd2);
          if (e.corr && modelCorr < 65535) modelCorr++;
          if (e.uncorr && modelUncorr < 65535) modelUncorr++;
        end
      end
      prevValid = out_valid;
      prevReady = out_ready;
      prevData  = out_data;
    end
  end

  task automatic checkCounters(input string tag);
`ifdef HAMMING_DEC_STATS_EN
    checkOutput({tag, "CorrCount"}, 32'(corr_count), 32'(modelCorr));
    checkOutput({tag, "UncorrCount"}, 32'(uncorr_count), 32'(modelUncorr));
`else
    checkOutput({tag, "CorrCount"}, 32'(corr_count), 32'd0);
    checkOutput({tag, "UncorrCount"}, 32'(uncorr_count), 32'd0);
`endif
  endtask

  initial begin
    expT dummy;
    bit acc;
    bit sawStall;
    int sent;
    logic [16:0] words [8];

    dummy = model(17'h0);
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetOutValid", 32'(out_valid), 32'd0);
    checkOutput("resetOutData", 32'(out_data), 32'd0);
    checkOutput("resetSyndrome", 32'(out_syndrome), 32'd0);
    checkOutput("resetCorrected", 32'(out_corrected), 32'd0);
    checkOutput("resetUncorr", 32'(out_uncorrectable), 32'd0);
    checkCounters("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("inReadyAfterReset", 32'(in_ready), 32'd1);

    // Directed words from the worked examples, back to back at full rate.
    sendDirected(17'h00000, 12'h000, 5'd0,  1'b0, 1'b0);
    sendDirected(17'h00007, 12'h001, 5'd0,  1'b0, 1'b0);
    sendDirected(17'h00017, 12'h001, 5'd5,  1'b1, 1'b0);
    sendDirected(17'h08004, 12'h001, 5'd19, 1'b0, 1'b1);
    sendDirected(17'h00003, 12'h001, 5'd3,  1'b1, 1'b0);
    sendDirected(17'h00001, 12'h000, 5'd1,  1'b1, 1'b0);
    idle(4, 1'b1);
    checkCounters("directed");

    // Eight-word stream with the sink stalled for three cycles mid-way.
    for (int i = 0; i < 8; i++) words[i] = randCode();
    sent = 0;
    sawStall = 1'b0;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      applyStimulus(1'b1, words[sent], !(c >= 3 && c <= 5), 1'b0, 1'b0, dummy, acc);
      if (!in_ready) sawStall = 1'b1;
      if (acc) sent++;
    end
    checkOutput("streamSent", 32'(sent), 32'd8);
    checkOutput("streamInReadyDrop", 32'(sawStall), 32'd1);
    idle(4, 1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, randCode(), $urandom_range(0, 3) != 0,
                    1'b0, 1'b0, dummy, acc);
    end
    idle(4, 1'b1);

    // Random traffic with the sink always ready: latency must be exactly 2.
    for (int i = 0; i < 150; i++) begin
      applyStimulus($urandom_range(0, 4) != 0, randCode(), 1'b1, 1'b1, 1'b0, dummy, acc);
    end
    idle(4, 1'b1);
    checkCounters("random");

    // Fill both stages, then reset and make sure nothing survives.
    for (int i = 0; i < 10 && in_ready; i++) begin
      applyStimulus(1'b1, randCode(), 1'b0, 1'b0, 1'b0, dummy, acc);
    end
    checkOutput("fillInReady", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    expQ.delete();
    modelCorr = 0;
    modelUncorr = 0;
    @(negedge clk);
    checkOutput("midResetOutValid", 32'(out_valid), 32'd0);
    checkOutput("midResetInReady", 32'(in_ready), 32'd1);
    checkCounters("midReset");
    sendDirected(17'h00017, 12'h001, 5'd5, 1'b1, 1'b0);

    // Bounded drain of everything still in flight.
    for (int i = 0; i < 20 && expQ.size() > 0; i++) idle(1, 1'b1);
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    idle(2, 1'b1);
    checkCounters("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_decoder_pipe.md
Name: hamming_decoder_pipe

Overview:
- Downstream consumer of the 12-bit/17-bit Hamming encoder; receives 17-bit codewords (bit positions 1..17) and returns the 12 data bits.
- Computes a 5-bit syndrome, corrects any single-bit error, and flags syndromes that point outside the codeword as uncorrectable.
- Two-stage valid/ready pipeline with full backpressure; sits between the channel/storage model and the data sink.

Parameters:
- CNT_W, 16, width of the saturating error-statistics counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  codeword present
- in_ready  output  1  decoder accepts in_code this cycle
- in_code  input  17 [17:1]  received codeword; parity at positions 1,2,4,8,16, data at the remaining positions in ascending order (data[0] at 3 ... data[11] at 17)
- out_valid  output  1  decoded word present
- out_ready  input  1  sink accepts
- out_data  output  12  corrected data
- out_syndrome  output  5  raw syndrome
- out_corrected  output  1  single error corrected (syndrome 1..17)
- out_uncorrectable  output  1  syndrome 18..31
- corr_count  output  CNT_W  corrected words (stats build only)
- uncorr_count  output  CNT_W  uncorrectable words (stats build only)

Behaviour:
- Parity groups: syndrome bit k (k=0..4) = XOR of all in_code positions p (1..17) whose binary index has bit k set, including the parity bit at 2^k. Zero syndrome = clean word.
- Stage 1 (S1): on in_valid && in_ready, register in_code and computed syndrome; s1_valid<=1.
- Stage 2 (S2): on S1->S2 transfer, flip position = syndrome if 1..17; extract data; register out_data, out_syndrome, out_corrected, out_uncorrectable; out_valid<=1.
- Syndrome 0: data passes unmodified, both flags 0. Syndrome 18..31: no bit flipped, data extracted raw, out_uncorrectable=1. Syndrome equal to a parity position: parity bit flipped, data unchanged, out_corrected=1.
- Double errors are not detected unless the syndrome exceeds 17; miscorrection is the defined behaviour.
- Handshake: S2 advances when !out_valid || out_ready; S1 advances into S2 under the same condition; in_ready = !s1_valid || (S1 advancing). Full throughput of one word/cycle with out_ready held high; latency exactly 2 cycles from acceptance to out_valid.
- Outputs stable while out_valid && !out_ready; no combinational path from in_valid to out_valid. The in_ready path from out_ready is combinational (allowed).
- Output on out_valid deassert: out_data and flags hold their last value.
- Reset: out_valid=0, s1_valid=0, out_data=0, out_syndrome=0, out_corrected=0, out_uncorrectable=0, counters=0. Reset asserted mid-transfer discards all in-flight words. in_ready=1 in the first cycle after reset release.

Optional Feature:
- Macro HAMMING_DEC_STATS_EN.
- Defined: corr_count/uncorr_count increment by 1 on each out_valid && out_ready handshake with the respective flag set. They saturate at all-ones and reset to 0.
- Undefined: no counter flops; both ports tied to 0.

Decomposition:
- Shared package: codeword width constant 17, data width 12, syndrome width 5, parity position list, data-position map function (data index -> codeword position).
- Sub-module hamming_syndrome: purely combinational; 17-bit codeword in, 5-bit syndrome out. Reused by checkers.

Test Plan:
- in_code=17'h00000 with out_ready=1 -> 2 cycles later out_data=12'h000, syndrome 0, both flags 0.
- in_code=17'h00007 (data 12'h001 clean) -> out_data=12'h001, syndrome 0. Then flip position 5 (17'h00017) -> syndrome 5, out_corrected=1, out_data=12'h001.
- in_code=17'h08004 (errors at positions 3 and 16 on the zero word) -> syndrome 19, out_uncorrectable=1, out_data=12'h001 raw. In a stats build, uncorr_count=1.
- in_code=17'h00003 (errors at positions 1 and 2) -> syndrome 3, miscorrected to out_data=12'h001, out_corrected=1.
- Stream 8 words, out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full; no loss or duplication; order is preserved.
- rst_n low for 1 cycle with both stages full -> out_valid=0 next cycle; counters=0; the next accepted word emerges after 2 cycles.
